if_fetch_stage: RTL and testbench

//  Instruction-fetch stage feeding the decode stage of the LoongArch core.

---
 rtl/if_fetch_stage.sv | 142 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC, inst SRAM request, instruction buffer, decode handshake
//
// Purpose: owns the fetch PC, issues one read per cycle to a 1-cycle-latency
// instruction SRAM and queues returned words with their PC in a small FIFO
// that feeds decode over a valid/allow-in handshake. A branch redirect
// flushes the buffer and restarts fetch at the target.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   inst_sram_en/we     read request this cycle; write enable tied low
//   inst_sram_addr      fetch address (RESET_PC while reset is high)
//   inst_sram_wdata     tied low
//   inst_sram_rdata     word for the address issued in the previous cycle
//   br_taken/br_target  redirect from decode; target bits [1:0] ignored
//   ds_allow_in         decode accepts an instruction this cycle
//   fs_to_ds_valid      {fs_pc, fs_inst} valid to decode
//   fs_pc, fs_inst      buffer head
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h1c00_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ds_allow_in,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             pending_q, pending_d;
  logic             cancel_q, cancel_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [31:0]      buf_pc_q   [BUF_DEPTH];
  logic [31:0]      buf_pc_d   [BUF_DEPTH];
  logic [31:0]      buf_inst_q [BUF_DEPTH];
  logic [31:0]      buf_inst_d [BUF_DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   occupancy;

  // Low target bits are architecturally zero for instruction addresses.
  logic unused_tgt_bits;
  assign unused_tgt_bits = ^br_target[1:0];

  assign inst_sram_we    = 1'b0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = reset ? RESET_PC : fetch_pc_q;
  assign inst_sram_en    = issue;

  assign fs_to_ds_valid = ~reset & (count_q != '0) & ~br_taken;
  assign fs_pc          = buf_pc_q[head_q];
  assign fs_inst        = buf_inst_q[head_q];

  always_comb begin
    pop  = fs_to_ds_valid & ds_allow_in;
    // The in-flight read already owns a buffer slot, so issue is throttled
    // on entries held plus the one arriving, less the one leaving.
    occupancy = (CNT_W+1)'(count_q) + (CNT_W+1)'(pending_q) - (CNT_W+1)'(pop);
    issue = ~reset & ~br_taken & (occupancy < (CNT_W+1)'(BUF_DEPTH));
    push  = ~reset & pending_q & ~cancel_q & ~br_taken;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    pending_d  = issue;
    // A redirect suppresses issue in its own cycle, so with a single-cycle
    // SRAM there is never a stale response to drop.
    cancel_d   = 1'b0;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;

    if (issue) begin
      req_pc_d = fetch_pc_q;
    end

    if (br_taken) begin
      fetch_pc_d = {br_target[31:2], 2'b00};
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        buf_pc_d[tail_q]   = req_pc_q;
        buf_inst_d[tail_q] = inst_sram_rdata;
        tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      pending_q  <= 1'b0;
      cancel_q   <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      buf_pc_q   <= '{default: '0};
      buf_inst_q <= '{default: '0};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pending_q  <= pending_d;
      cancel_q   <= cancel_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        ds_allow_in = 1'b1;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;

  int total = 0;
  int bad = 0;

  if_fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .inst_sram_en(inst_sram_en),
    .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .br_taken(br_taken),
    .br_target(br_target),
    .ds_allow_in(ds_allow_in),
    .fs_to_ds_valid(fs_to_ds_valid),
    .fs_pc(fs_pc),
    .fs_inst(fs_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a3c_96e1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: answers the request seen in a cycle during the next
  // cycle; garbage otherwise so that spurious pushes are visible.
  logic        s_en;
  logic [31:0] s_addr;
  always @(negedge clk) begin
    s_en   = inst_sram_en;
    s_addr = inst_sram_addr;
  end
  always @(posedge clk) begin
    #1;
    inst_sram_rdata = s_en ? mem_word(s_addr) : $urandom();
  end

  // Transaction-level reference: fetch address, queue of buffered PCs and
  // the address of the read currently in flight.
  logic [31:0] m_fetch = RST_PC;
  logic [31:0] m_q[$];
  bit          m_pend = 0;
  logic [31:0] m_pend_pc = 32'h0;

  always @(negedge clk) begin
    automatic bit e_valid, e_en, e_pop;
    automatic logic [31:0] e_addr;
    if (reset) begin
      e_valid = 0;
      e_en    = 0;
      e_addr  = RST_PC;
      e_pop   = 0;
    end else begin
      e_valid = (m_q.size() > 0) && !br_taken;
      e_pop   = e_valid && ds_allow_in;
      e_en    = !br_taken && (m_q.size() + int'(m_pend) - int'(e_pop) < DEPTH);
      e_addr  = m_fetch;
    end
    chk("model_en", 32'(inst_sram_en), 32'(e_en));
    chk("model_addr", inst_sram_addr, e_addr);
    chk("model_valid", 32'(fs_to_ds_valid), 32'(e_valid));
    chk("model_we_wdata", {inst_sram_wdata[30:0], inst_sram_we}, 32'h0);
    if (e_valid) begin
      chk("model_pc", fs_pc, m_q[0]);
      chk("model_inst", fs_inst, mem_word(m_q[0]));
    end
    if (reset) begin
      m_fetch = RST_PC;
      m_q.delete();
      m_pend = 0;
    end else if (br_taken) begin
      m_q.delete();
      m_fetch = br_target & 32'hffff_fffc;
      m_pend = 0;
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (m_pend) m_q.push_back(m_pend_pc);
      m_pend = e_en;
      if (e_en) begin
        m_pend_pc = m_fetch;
        m_fetch = m_fetch + 32'd4;
      end
    end
  end

  task automatic cyc(input bit rst, input bit br, input logic [31:0] tgt, input bit allow);
    @(posedge clk);
    #1;
    reset = rst;
    br_taken = br;
    br_target = tgt;
    ds_allow_in = allow;
    #1;
  endtask

  initial begin
    // Reset and first fetches.
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("rst_en", 32'(inst_sram_en), 32'h0);
    chk("rst_valid", 32'(fs_to_ds_valid), 32'h0);
    chk("rst_addr", inst_sram_addr, 32'h1c00_0000);
    cyc(0, 0, 0, 1);
    chk("r0_en", 32'(inst_sram_en), 32'h1);
    chk("r0_addr", inst_sram_addr, 32'h1c00_0000);
    chk("r0_valid", 32'(fs_to_ds_valid), 32'h0);
    cyc(0, 0, 0, 1);
    chk("r1_addr", inst_sram_addr, 32'h1c00_0004);
    chk("r1_valid", 32'(fs_to_ds_valid), 32'h0);
    cyc(0, 0, 0, 1);
    chk("r2_valid", 32'(fs_to_ds_valid), 32'h1);
    chk("r2_pc", fs_pc, 32'h1c00_0000);
    chk("r2_inst", fs_inst, 32'h0000_1c00 ^ 32'h5a3c_96e1);
    cyc(0, 0, 0, 1);
    chk("r3_pc", fs_pc, 32'h1c00_0004);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);

    // Decode stall fills the buffer and stops requests.
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    chk("stall_en", 32'(inst_sram_en), 32'h0);
    chk("stall_valid", 32'(fs_to_ds_valid), 32'h1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

    // Redirect with a read in flight and a stalled decode.
    cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h1c00_0100, 0);
    chk("br_t_valid", 32'(fs_to_ds_valid), 32'h0);
    chk("br_t_en", 32'(inst_sram_en), 32'h0);
    cyc(0, 0, 0, 1);
    chk("br_t1_valid", 32'(fs_to_ds_valid), 32'h0);
    chk("br_t1_addr", inst_sram_addr, 32'h1c00_0100);
    chk("br_t1_en", 32'(inst_sram_en), 32'h1);
    cyc(0, 0, 0, 1);
    chk("br_t2_valid", 32'(fs_to_ds_valid), 32'h0);
    cyc(0, 0, 0, 1);
    chk("br_t3_valid", 32'(fs_to_ds_valid), 32'h1);
    chk("br_t3_pc", fs_pc, 32'h1c00_0100);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // Redirect while decode is accepting: no transfer in that cycle.
    cyc(0, 1, 32'h1c00_0203, 1);
    chk("br_pop_valid", 32'(fs_to_ds_valid), 32'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    chk("br_pop_pc", fs_pc, 32'h1c00_0200);

    // One-cycle reset mid-stream.
    cyc(1, 0, 0, 1);
    chk("mrst_en", 32'(inst_sram_en), 32'h0);
    chk("mrst_valid", 32'(fs_to_ds_valid), 32'h0);
    chk("mrst_addr", inst_sram_addr, 32'h1c00_0000);
    cyc(0, 0, 0, 1);
    chk("mrst_r0_en", 32'(inst_sram_en), 32'h1);
    chk("mrst_r0_addr", inst_sram_addr, 32'h1c00_0000);
    chk("mrst_r0_valid", 32'(fs_to_ds_valid), 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // Address wrap at the top of the address space.
    cyc(0, 1, 32'hffff_fffe, 1);
    cyc(0, 0, 0, 1);
    chk("wrap_a0", inst_sram_addr, 32'hffff_fffc);
    cyc(0, 0, 0, 1);
    chk("wrap_a1", inst_sram_addr, 32'h0000_0000);
    cyc(0, 0, 0, 1);
    chk("wrap_pc0", fs_pc, 32'hffff_fffc);
    cyc(0, 0, 0, 1);
    chk("wrap_pc1", fs_pc, 32'h0000_0000);
    chk("wrap_inst1", fs_inst, 32'h5a3c_96e1);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      automatic int r = $urandom_range(0, 99);
      automatic logic [31:0] t = $urandom();
      if ($urandom_range(0, 3) == 0) t = 32'hffff_fff0 | (t & 32'hf);
      cyc(r < 1, (r >= 1) && (r < 9), t, $urandom_range(0, 9) < 7);
    end
    cyc(0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
